// File: rtl/bytebeat_pwm_sink.sv
// Bytebeat sample sink: one-entry buffered valid/ready input, sample-rate divider, PWM audio output.
// Optional macro BYTEBEAT_SIGMA_DELTA_EN swaps the PWM comparator for a first-order sigma-delta modulator.
module bytebeat_pwm_sink #(
    parameter int PWM_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sample,
    input  logic             sample_vld,
    output logic             sample_rdy,
    input  logic [DIV_W-1:0] sample_div,
    output logic             pwm_out,
    output logic             sample_strobe,
    output logic [7:0]       underrun_cnt
);

    logic [PWM_W-1:0] pwm_cnt;
    logic [DIV_W-1:0] frame_cnt;
    logic [7:0]       buf_data;
    logic             buf_valid;
    logic [7:0]       duty;
    logic             frame_end;
    logic             tick;
    logic             xfer;

    // Valid/ready: a sample moves when sample_vld & sample_rdy are both high at a rising
    // clk edge; sample_rdy is a pure function of buffer state and never looks at sample_vld.
    assign sample_rdy = ~buf_valid & ~reset;
    assign xfer       = sample_vld & sample_rdy;

    assign frame_end = (pwm_cnt == '1);
    // >= lets a lowered divider take effect at the next frame end instead of wrapping
    assign tick      = frame_end & (frame_cnt >= sample_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt       <= '0;
            frame_cnt     <= '0;
            buf_data      <= '0;
            buf_valid     <= 1'b0;
            duty          <= 8'h80;
            sample_strobe <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            pwm_cnt       <= pwm_cnt + PWM_W'(1);
            sample_strobe <= tick & buf_valid;

            if (tick) begin
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + DIV_W'(1);
            end

            if (tick) begin
                if (buf_valid) begin
                    duty      <= buf_data;
                    buf_valid <= 1'b0;
                end else if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end

            // xfer only happens with the buffer empty, so it never collides with the consume above
            if (xfer) begin
                buf_data  <= sample;
                buf_valid <= 1'b1;
            end
        end
    end

`ifdef BYTEBEAT_SIGMA_DELTA_EN
    logic [8:0] acc;
    logic [8:0] acc_next;

    assign acc_next = {1'b0, acc[7:0]} + {1'b0, duty};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            pwm_out <= 1'b0;
        end else begin
            acc     <= acc_next;
            pwm_out <= acc_next[8];
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (pwm_cnt < duty);
        end
    end
`endif

endmodule
